// File: rtl/level_sequencer_if.sv
// Bundle between the game-flow sequencer and its environment.
// The master side is the sequencer: it takes keyboard/level status and drives
// level enables, the level reset pulse and the HUD status. The slave side is
// everything around it: the keyboard decode, the level blocks and the HUD.
interface level_sequencer_if;

    // keyboard decode -> sequencer
    logic       start_game;

    // level blocks -> sequencer
    logic [2:0] lvl_done;
    logic [2:0] lvl_guesses0;
    logic [2:0] lvl_guesses1;
    logic [2:0] lvl_guesses2;

    // sequencer -> level blocks
    logic [2:0] lvl_start;
    logic       lvl_reset;

    // sequencer -> HUD
    logic [1:0] curr_level;
    logic [2:0] lives;
    logic [7:0] score;
    logic       game_over;
    logic       game_won;

    modport master (
        input  start_game,
        input  lvl_done,
        input  lvl_guesses0,
        input  lvl_guesses1,
        input  lvl_guesses2,
        output lvl_start,
        output lvl_reset,
        output curr_level,
        output lives,
        output score,
        output game_over,
        output game_won
    );

    modport slave (
        output start_game,
        output lvl_done,
        output lvl_guesses0,
        output lvl_guesses1,
        output lvl_guesses2,
        input  lvl_start,
        input  lvl_reset,
        input  curr_level,
        input  lives,
        input  score,
        input  game_over,
        input  game_won
    );

endinterface

// File: rtl/level_sequencer.sv
// Game-flow controller for the three lock-pick levels (easy/medium/hard).
// Runs one level at a time: a one-cycle ARM state pulses the level's reset,
// PLAY enables the level and watches only its done flag and guess count,
// SOLVED/FAILED show a banner for a fixed time, and LOST/WON wait for a new
// game. A solve is only accepted once the done flag has been held high for
// HOLD_CYCLES consecutive cycles, which filters glitches on the combinational
// done flags. Every HUD and level-control output comes straight from a flop.
module level_sequencer #(
    parameter int MAX_GUESSES = 6,
    parameter int LIVES       = 3,
    parameter int HOLD_CYCLES = 25000000,
    parameter int SHOW_CYCLES = 50000000
) (
    input  logic               Clk,
    input  logic               reset,
    level_sequencer_if.master  bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int SHOW_W = $clog2(SHOW_CYCLES + 1);

    // Last counter value before the threshold: compare against this so the
    // counter never needs to represent more than its parameter.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYCLES - 1);
    localparam logic [SHOW_W-1:0] SHOW_ONE  = SHOW_W'(1);
    localparam logic [SHOW_W-1:0] SHOW_ZERO = SHOW_W'(0);

    localparam logic [2:0] MAX_G      = 3'(MAX_GUESSES);
    localparam logic [2:0] LIVES_INIT = 3'(LIVES);

    // curr_level value shown whenever no level is active
    localparam logic [1:0] NO_LEVEL   = 2'd3;
    localparam logic [1:0] LAST_LEVEL = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_PLAY   = 3'd2,
        ST_SOLVED = 3'd3,
        ST_FAILED = 3'd4,
        ST_LOST   = 3'd5,
        ST_WON    = 3'd6
    } state_e;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // One-hot enable for a level index; index 3 (no level) gives all zeros.
    function automatic logic [2:0] level_onehot(input logic [1:0] lvl);
        logic [2:0] oh;
        case (lvl)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Score after a solve: award the unused guesses, saturating at 255.
    // A guess count at or above the limit awards nothing.
    function automatic logic [7:0] score_after_solve(input logic [7:0] cur,
                                                     input logic [2:0] guesses);
        logic [2:0] award;
        logic [8:0] sum;
        if (guesses >= MAX_G) begin
            award = 3'd0;
        end else begin
            award = MAX_G - guesses;
        end
        sum = {1'b0, cur} + {6'd0, award};
        if (sum[8]) begin
            return 8'hFF;
        end else begin
            return sum[7:0];
        end
    endfunction

    // Lives after a failed level; never wraps below zero.
    function automatic logic [2:0] lives_after_fail(input logic [2:0] cur);
        if (cur == 3'd0) begin
            return 3'd0;
        end else begin
            return cur - 3'd1;
        end
    endfunction

    // ------------------------------------------------------------------
    // State and output flops
    // ------------------------------------------------------------------
    state_e            state_q,      state_d;
    logic [1:0]        level_q,      level_d;
    logic [HOLD_W-1:0] hold_q,       hold_d;
    logic [SHOW_W-1:0] show_q,       show_d;
    logic [2:0]        lvl_start_q,  lvl_start_d;
    logic              lvl_reset_q,  lvl_reset_d;
    logic [1:0]        curr_level_q, curr_level_d;
    logic [2:0]        lives_q,      lives_d;
    logic [7:0]        score_q,      score_d;
    logic              game_over_q,  game_over_d;
    logic              game_won_q,   game_won_d;

    // Status of the selected level only
    logic              sel_done_s;
    logic [2:0]        sel_guesses_s;
    logic              solve_now_s;
    logic              limit_hit_s;
    logic [HOLD_W-1:0] hold_next_s;

    // Route the active level's done flag and guess count; others are ignored.
    always_comb begin
        sel_done_s    = 1'b0;
        sel_guesses_s = 3'd0;
        case (level_q)
            2'd0: begin
                sel_done_s    = bus.lvl_done[0];
                sel_guesses_s = bus.lvl_guesses0;
            end
            2'd1: begin
                sel_done_s    = bus.lvl_done[1];
                sel_guesses_s = bus.lvl_guesses1;
            end
            2'd2: begin
                sel_done_s    = bus.lvl_done[2];
                sel_guesses_s = bus.lvl_guesses2;
            end
            default: begin
                sel_done_s    = 1'b0;
                sel_guesses_s = 3'd0;
            end
        endcase
    end

    // Hold-counter bookkeeping: a solve is confirmed on the cycle the run of
    // consecutive done cycles reaches HOLD_CYCLES.
    always_comb begin
        solve_now_s = sel_done_s && (hold_q == HOLD_LAST);
        limit_hit_s = (sel_guesses_s >= MAX_G);
        if (sel_done_s) begin
            hold_next_s = hold_q + HOLD_ONE;
        end else begin
            hold_next_s = HOLD_ZERO;
        end
    end

    // Next-state and next-output logic of the game-flow FSM.
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        hold_d       = hold_q;
        show_d       = show_q;
        lvl_start_d  = lvl_start_q;
        lvl_reset_d  = 1'b0;
        curr_level_d = curr_level_q;
        lives_d      = lives_q;
        score_d      = score_q;
        game_over_d  = game_over_q;
        game_won_d   = game_won_q;

        case (state_q)
            ST_IDLE, ST_LOST, ST_WON: begin
                if (bus.start_game) begin
                    // fresh game from level 0
                    state_d      = ST_ARM;
                    level_d      = 2'd0;
                    hold_d       = HOLD_ZERO;
                    lvl_start_d  = 3'b000;
                    lvl_reset_d  = 1'b1;
                    curr_level_d = 2'd0;
                    lives_d      = LIVES_INIT;
                    score_d      = 8'd0;
                    game_over_d  = 1'b0;
                    game_won_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end

            ST_ARM: begin
                // level reset pulse has been out for one cycle; enable level
                state_d      = ST_PLAY;
                hold_d       = HOLD_ZERO;
                lvl_start_d  = level_onehot(level_q);
                curr_level_d = level_q;
            end

            ST_PLAY: begin
                if (solve_now_s) begin
                    // solve outranks a guess limit reached in the same cycle
                    state_d     = ST_SOLVED;
                    hold_d      = hold_next_s;
                    show_d      = SHOW_ZERO;
                    lvl_start_d = 3'b000;
                    score_d     = score_after_solve(score_q, sel_guesses_s);
                end else if (limit_hit_s) begin
                    state_d     = ST_FAILED;
                    hold_d      = hold_next_s;
                    show_d      = SHOW_ZERO;
                    lvl_start_d = 3'b000;
                    lives_d     = lives_after_fail(lives_q);
                end else begin
                    state_d     = ST_PLAY;
                    hold_d      = hold_next_s;
                    lvl_start_d = level_onehot(level_q);
                end
            end

            ST_SOLVED: begin
                if (show_q == SHOW_LAST) begin
                    if (level_q < LAST_LEVEL) begin
                        state_d      = ST_ARM;
                        level_d      = level_q + 2'd1;
                        hold_d       = HOLD_ZERO;
                        lvl_reset_d  = 1'b1;
                        curr_level_d = level_q + 2'd1;
                    end else begin
                        state_d      = ST_WON;
                        game_won_d   = 1'b1;
                        curr_level_d = NO_LEVEL;
                    end
                end else begin
                    show_d = show_q + SHOW_ONE;
                end
            end

            ST_FAILED: begin
                if (show_q == SHOW_LAST) begin
                    if (lives_q == 3'd0) begin
                        state_d      = ST_LOST;
                        game_over_d  = 1'b1;
                        curr_level_d = NO_LEVEL;
                    end else begin
                        // retry the same level
                        state_d      = ST_ARM;
                        hold_d       = HOLD_ZERO;
                        lvl_reset_d  = 1'b1;
                        curr_level_d = level_q;
                    end
                end else begin
                    show_d = show_q + SHOW_ONE;
                end
            end

            default: begin
                // unreachable encoding: fall back to the idle/reset picture
                state_d      = ST_IDLE;
                level_d      = 2'd0;
                hold_d       = HOLD_ZERO;
                show_d       = SHOW_ZERO;
                lvl_start_d  = 3'b000;
                curr_level_d = NO_LEVEL;
                lives_d      = LIVES_INIT;
                score_d      = 8'd0;
                game_over_d  = 1'b0;
                game_won_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops every output at once.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            level_q      <= 2'd0;
            hold_q       <= HOLD_ZERO;
            show_q       <= SHOW_ZERO;
            lvl_start_q  <= 3'b000;
            lvl_reset_q  <= 1'b0;
            curr_level_q <= NO_LEVEL;
            lives_q      <= LIVES_INIT;
            score_q      <= 8'd0;
            game_over_q  <= 1'b0;
            game_won_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            hold_q       <= hold_d;
            show_q       <= show_d;
            lvl_start_q  <= lvl_start_d;
            lvl_reset_q  <= lvl_reset_d;
            curr_level_q <= curr_level_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            game_over_q  <= game_over_d;
            game_won_q   <= game_won_d;
        end
    end

    assign bus.lvl_start  = lvl_start_q;
    assign bus.lvl_reset  = lvl_reset_q;
    assign bus.curr_level = curr_level_q;
    assign bus.lives      = lives_q;
    assign bus.score      = score_q;
    assign bus.game_over  = game_over_q;
    assign bus.game_won   = game_won_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Bench for level_sequencer with small timing parameters.
// Inputs change 1 time unit after the rising edge; outputs are compared
// 1 time unit after the next rising edge against values from a queue.
module tb_level_sequencer;

    localparam int P_MAXG = 3;
    localparam int P_LIVES = 2;
    localparam int P_HOLD = 4;
    localparam int P_SHOW = 5;

    logic Clk;
    logic reset;

    level_sequencer_if bus_if();

    level_sequencer #(
        .MAX_GUESSES (P_MAXG),
        .LIVES       (P_LIVES),
        .HOLD_CYCLES (P_HOLD),
        .SHOW_CYCLES (P_SHOW)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // packed output picture: lvl_start, lvl_reset, curr_level, lives, score, over, won
    typedef struct {
        logic        st;
        logic [2:0]  dn;
        logic [2:0]  g0;
        logic [2:0]  g1;
        logic [2:0]  g2;
        logic [18:0] ex;
    } vec_t;

    vec_t        tbl[$];
    logic [18:0] sb_q[$];
    int          n_pass;
    int          n_total;
    int          m_score;
    int          m_lives;

    function automatic logic [18:0] pk(input logic [2:0] ls, input logic rs,
                                       input logic [1:0] cl, input logic [2:0] lv,
                                       input logic [7:0] sc, input logic ov,
                                       input logic wn);
        return {ls, rs, cl, lv, sc, ov, wn};
    endfunction

    function automatic vec_t mk(input logic st, input logic [2:0] dn,
                                input logic [2:0] g0, input logic [2:0] g1,
                                input logic [2:0] g2, input logic [18:0] ex);
        vec_t v;
        v.st = st; v.dn = dn; v.g0 = g0; v.g1 = g1; v.g2 = g2; v.ex = ex;
        return v;
    endfunction

    function automatic string fmt(input logic [18:0] v);
        return $sformatf("start=%b rst=%b lvl=%0d lives=%0d score=%0d over=%b won=%b",
                         v[18:16], v[15], v[14:13], v[12:10], v[9:2], v[1], v[0]);
    endfunction

    task automatic check_out(input string nm);
        logic [18:0] got;
        logic [18:0] ex;
        got = {bus_if.lvl_start, bus_if.lvl_reset, bus_if.curr_level, bus_if.lives,
               bus_if.score, bus_if.game_over, bus_if.game_won};
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got %s", nm, fmt(got));
        end else begin
            ex = sb_q.pop_front();
            if (got === ex) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %s, expected %s", nm, fmt(got), fmt(ex));
            end
        end
    endtask

    task automatic apply(input logic st, input logic [2:0] dn, input logic [2:0] g0,
                         input logic [2:0] g1, input logic [2:0] g2,
                         input logic [18:0] ex, input string nm);
        bus_if.start_game   = st;
        bus_if.lvl_done     = dn;
        bus_if.lvl_guesses0 = g0;
        bus_if.lvl_guesses1 = g1;
        bus_if.lvl_guesses2 = g2;
        sb_q.push_back(ex);
        @(posedge Clk);
        #1;
        check_out(nm);
    endtask

    // Hold the active level's done flag until the solve confirms, then ride
    // out the banner. Starts with that level already in PLAY.
    task automatic solve_level(input int lv, input logic [2:0] g);
        logic [2:0] oh;
        logic [1:0] l2;
        int         award;
        oh = 3'b001 << lv;
        l2 = 2'(lv);
        for (int i = 0; i < P_HOLD - 1; i++) begin
            apply(1'b0, oh, g, g, g,
                  pk(oh, 1'b0, l2, 3'(m_lives), 8'(m_score), 1'b0, 1'b0), "hold_play");
        end
        award = (int'(g) >= P_MAXG) ? 0 : P_MAXG - int'(g);
        m_score = (m_score + award > 255) ? 255 : m_score + award;
        apply(1'b0, oh, g, g, g,
              pk(3'b000, 1'b0, l2, 3'(m_lives), 8'(m_score), 1'b0, 1'b0), "solve_confirm");
        for (int i = 0; i < P_SHOW - 1; i++) begin
            apply(1'b0, 3'b000, g, g, g,
                  pk(3'b000, 1'b0, l2, 3'(m_lives), 8'(m_score), 1'b0, 1'b0), "solved_banner");
        end
        if (lv < 2) begin
            apply(1'b0, 3'b000, 3'd0, 3'd0, 3'd0,
                  pk(3'b000, 1'b1, 2'(lv + 1), 3'(m_lives), 8'(m_score), 1'b0, 1'b0), "arm_next");
        end else begin
            apply(1'b0, 3'b000, 3'd0, 3'd0, 3'd0,
                  pk(3'b000, 1'b0, 2'd3, 3'(m_lives), 8'(m_score), 1'b0, 1'b1), "won");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        bus_if.start_game   = 1'b0;
        bus_if.lvl_done     = 3'b000;
        bus_if.lvl_guesses0 = 3'd0;
        bus_if.lvl_guesses1 = 3'd0;
        bus_if.lvl_guesses2 = 3'd0;

        // ---------------- main flow table ----------------
        tbl.push_back(mk(1'b1, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b000, 1'b1, 2'd0, 3'd2, 8'd0, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b001, 1'b0, 2'd0, 3'd2, 8'd0, 1'b0, 1'b0)));
        // done held 3 cycles (other levels' flags/guesses noisy), then dropped
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 3'b011, 3'd1, 3'd3, 3'd3, pk(3'b001, 1'b0, 2'd0, 3'd2, 8'd0, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 3'b000, 3'd1, 3'd0, 3'd0, pk(3'b001, 1'b0, 2'd0, 3'd2, 8'd0, 1'b0, 1'b0)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 3'b001, 3'd1, 3'd0, 3'd0, pk(3'b001, 1'b0, 2'd0, 3'd2, 8'd0, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 3'b001, 3'd1, 3'd0, 3'd0, pk(3'b000, 1'b0, 2'd0, 3'd2, 8'd2, 1'b0, 1'b0)));
        // solved banner, start_game pressed once and ignored
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(i == 1, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b000, 1'b0, 2'd0, 3'd2, 8'd2, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b000, 1'b1, 2'd1, 3'd2, 8'd2, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b010, 1'b0, 2'd1, 3'd2, 8'd2, 1'b0, 1'b0)));
        // level 1 guesses ramp; level 0 done/guesses ignored
        tbl.push_back(mk(1'b0, 3'b001, 3'd3, 3'd1, 3'd0, pk(3'b010, 1'b0, 2'd1, 3'd2, 8'd2, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 3'b001, 3'd3, 3'd2, 3'd0, pk(3'b010, 1'b0, 2'd1, 3'd2, 8'd2, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 3'b001, 3'd3, 3'd3, 3'd0, pk(3'b000, 1'b0, 2'd1, 3'd1, 8'd2, 1'b0, 1'b0)));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b000, 1'b0, 2'd1, 3'd1, 8'd2, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b000, 1'b1, 2'd1, 3'd1, 8'd2, 1'b0, 1'b0)));
        // start_game ignored in ARM and in PLAY
        tbl.push_back(mk(1'b1, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b010, 1'b0, 2'd1, 3'd1, 8'd2, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b1, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b010, 1'b0, 2'd1, 3'd1, 8'd2, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 3'b000, 3'd0, 3'd3, 3'd0, pk(3'b000, 1'b0, 2'd1, 3'd0, 8'd2, 1'b0, 1'b0)));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b000, 1'b0, 2'd1, 3'd0, 8'd2, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b000, 1'b0, 2'd3, 3'd0, 8'd2, 1'b1, 1'b0)));
        tbl.push_back(mk(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b000, 1'b0, 2'd3, 3'd0, 8'd2, 1'b1, 1'b0)));
        // restart from LOST
        tbl.push_back(mk(1'b1, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b000, 1'b1, 2'd0, 3'd2, 8'd0, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b001, 1'b0, 2'd0, 3'd2, 8'd0, 1'b0, 1'b0)));
        // hold reaches 4 in the same cycle guesses reach 3: solve wins
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 3'b001, 3'd2, 3'd0, 3'd0, pk(3'b001, 1'b0, 2'd0, 3'd2, 8'd0, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 3'b001, 3'd3, 3'd0, 3'd0, pk(3'b000, 1'b0, 2'd0, 3'd2, 8'd0, 1'b0, 1'b0)));

        // ---------------- reset state ----------------
        sb_q.push_back(pk(3'b000, 1'b0, 2'd3, 3'd2, 8'd0, 1'b0, 1'b0));
        @(posedge Clk);
        #1;
        check_out("reset_state");
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].st, tbl[i].dn, tbl[i].g0, tbl[i].g1, tbl[i].g2, tbl[i].ex,
                  $sformatf("table_%0d", i));
        end

        // reset during the solved banner
        reset = 1'b1;
        #1;
        sb_q.push_back(pk(3'b000, 1'b0, 2'd3, 3'd2, 8'd0, 1'b0, 1'b0));
        check_out("reset_in_banner");
        @(posedge Clk);
        #1;
        reset = 1'b0;

        // ---------------- clear all three levels ----------------
        m_score = 0;
        m_lives = P_LIVES;
        apply(1'b1, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b000, 1'b1, 2'd0, 3'd2, 8'd0, 1'b0, 1'b0), "won_start");
        for (int lv = 0; lv < 3; lv++) begin
            apply(1'b0, 3'b000, 3'd0, 3'd0, 3'd0,
                  pk(3'b001 << lv, 1'b0, 2'(lv), 3'd2, 8'(m_score), 1'b0, 1'b0), "won_play");
            solve_level(lv, 3'd0);
        end
        apply(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b000, 1'b0, 2'd3, 3'd2, 8'd9, 1'b0, 1'b1), "won_hold");
        m_score = 0;
        apply(1'b1, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b000, 1'b1, 2'd0, 3'd2, 8'd0, 1'b0, 1'b0), "restart_won");
        apply(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b001, 1'b0, 2'd0, 3'd2, 8'd0, 1'b0, 1'b0), "restart_play");

        // ---------------- reach level 2, then async reset ----------------
        solve_level(0, 3'd1);
        apply(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b010, 1'b0, 2'd1, 3'd2, 8'd2, 1'b0, 1'b0), "play_l1");
        solve_level(1, 3'd2);
        apply(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b100, 1'b0, 2'd2, 3'd2, 8'd3, 1'b0, 1'b0), "play_l2");
        apply(1'b1, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b100, 1'b0, 2'd2, 3'd2, 8'd3, 1'b0, 1'b0), "start_in_play");
        #2;
        reset = 1'b1;
        bus_if.start_game = 1'b0;
        #1;
        sb_q.push_back(pk(3'b000, 1'b0, 2'd3, 3'd2, 8'd0, 1'b0, 1'b0));
        check_out("async_reset_same_cycle");
        @(posedge Clk);
        #1;
        sb_q.push_back(pk(3'b000, 1'b0, 2'd3, 3'd2, 8'd0, 1'b0, 1'b0));
        check_out("async_reset_held");
        reset = 1'b0;
        apply(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b000, 1'b0, 2'd3, 3'd2, 8'd0, 1'b0, 1'b0), "idle_after_reset");
        apply(1'b1, 3'b000, 3'd0, 3'd0, 3'd0, pk(3'b000, 1'b1, 2'd0, 3'd2, 8'd0, 1'b0, 1'b0), "start_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
